scan_design_cell: RTL and testbench
===================================

// Module: scan_design_cell
// PURPOSE
//   One link of the scan chain driven by scan_controller; one instance per user design.
//   Shifts serial data on scan_clk rising edges and latches the shifted word onto the design inputs.
//   Captures the design outputs back into the chain for readout.
//   Runs in the controller's clk domain: all scan signals are synchronous to clk, so no synchronisers.
// PARAMETERS
//   NUM_IOS   8   width of the design input and output buses and of the internal shift register
// PORTS
//   clk                    in   1        system clock, same clock as scan_controller
//   reset                  in   1        synchronous, active-high
//   scan_clk_in            in   1        scan clock level from the previous link
//   scan_data_in           in   1        serial data from the previous link
//   scan_select_in         in   1        1 = shift mode, 0 = capture mode
//   scan_latch_enable_in   in   1        1 = transfer shift register to design inputs
//   scan_clk_out           out  1        scan_clk_in passed through combinationally
//   scan_select_out        out  1        scan_select_in passed through combinationally
//   scan_latch_enable_out  out  1        scan_latch_enable_in passed through combinationally
//   scan_data_out          out  1        shift_reg[NUM_IOS-1], serial data to the next link
//   design_inputs          out  NUM_IOS  latched inputs applied to the user design
//   design_outputs         in   NUM_IOS  outputs of the user design
//   inputs_valid           out  1        1 once a latch has occurred since reset
//   shift_count            out  8        number of shifts since the last latch; saturates at 255
// BEHAVIOUR
//   Reset values: shift_reg=0, design_inputs=0, inputs_valid=0, shift_count=0, scan_clk_prev=0.
//   - scan_data_out is therefore 0 out of reset.
//   Edge detect: scan_clk_prev <= scan_clk_in every cycle.
//   - rise = scan_clk_in & ~scan_clk_prev. Falling edges are ignored.
//   Shift: in a cycle where rise=1 and scan_select_in=1:
//   - shift_reg <= {shift_reg[NUM_IOS-2:0], scan_data_in}; this is MSB-first.
//   - After NUM_IOS shifts, the first bit sent sits in shift_reg[NUM_IOS-1].
//   - The next link and the controller sample the pre-shift scan_data_out on the same clk edge.
//   - Result: the chain behaves as one contiguous shift register, one bit per scan_clk rise.
//   Capture: in a cycle where scan_select_in=0 and scan_latch_enable_in=0:
//   - shift_reg <= design_outputs. This is level-sensitive and repeats every such cycle.
//   - rise is ignored while scan_select_in=0.
//   Latch: in a cycle where scan_latch_enable_in=1:
//   - design_inputs <= shift_reg (value before any same-cycle shift).
//   - inputs_valid <= 1; shift_count <= 0.
//   shift_count: increments by 1 on each shift, saturates at 255.
//   - Latch in the same cycle as a shift: the latch wins and shift_count goes to 0.
//   Latch and shift in the same cycle: both happen.
//   - design_inputs gets the old shift_reg; shift_reg shifts.
//   Latch with scan_select_in=0: latch only, no capture that cycle.
//   Latency: one clk from the qualifying cycle to the shift_reg, design_inputs and scan_data_out update.
//   design_inputs hold their value between latches.
//   - Shifting never disturbs the running design.
//   Reset mid-shift or mid-read: all state returns to reset values on the next edge.
//   - The partial word is lost.
//   - The controller restarts its frame from START after reset.
//   Pass-through outputs are combinational.
//   - Every link sees an identical scan_clk phase, so edge detection stays aligned along the chain.
//   - Chain depth is limited by combinational delay; this is accepted for up to 256 links.
// STRUCTURE
//   Shared package:
//   - NUM_IOS default
//   - SCAN_SHIFT=1 / SCAN_CAPTURE=0 select encoding
//   - shift_count width (8)
//   No sub-module: edge detect, shift register, latch register and counter live in one module.
//   Chain top: a generate loop instantiates NUM_DESIGNS cells between scan_controller out and in.
// TESTING
//   1. Reset, then idle -> design_inputs=0, scan_data_out=0, inputs_valid=0, shift_count=0.
//   2. Select=1, shift 0xA5 MSB-first over 8 scan_clk rises, then pulse latch for 1 cycle
//      -> design_inputs=0xA5 one clk later, inputs_valid=1, shift_count=0.
//   3. design_outputs=0x3C, select=0 for 1 cycle, then select=1 with 8 rises
//      -> scan_data_out sequence 0,0,1,1,1,1,0,0 sampled at each rise; design_inputs unchanged.
//   4. Hold scan_clk_in=1 for 5 cycles with select=1 -> exactly one shift, shift_count=1.
//   5. Latch asserted on the same cycle as a rise, shift_reg=0xFF, data_in=0
//      -> design_inputs=0xFF, shift_reg=0xFE, shift_count=0.
//   6. Reset after 4 of 8 shifts -> all state 0; 8 new shifts of 0x5A plus a latch give design_inputs=0x5A.

Source files
------------

// File: rtl/scan_design_cell_pkg.sv
// Shared definitions for the scan chain cell: default width, select
// encoding and the shift counter width with its saturating increment.
package scan_design_cell_pkg;

   localparam int NUM_IOS_DEFAULT = 8;
   localparam int SHIFT_COUNT_W   = 8;

   localparam logic [SHIFT_COUNT_W-1:0] SHIFT_COUNT_MAX = '1;

   typedef enum logic {
      SCAN_CAPTURE = 1'b0,
      SCAN_SHIFT   = 1'b1
   } scan_mode_e;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [SHIFT_COUNT_W-1:0] sat_inc(
      input logic [SHIFT_COUNT_W-1:0] value
   );
      if (value == SHIFT_COUNT_MAX) begin
         return value;
      end
      return value + 1'b1;
   endfunction

endpackage : scan_design_cell_pkg

// File: rtl/scan_design_cell_if.sv
// Scan chain link bundle: clock level, serial data, select and latch enable.
// The upstream side of a link drives it (master), the cell reads it (slave).
interface scan_design_cell_if;

   logic scan_clk;
   logic scan_data;
   logic scan_select;
   logic scan_latch_enable;

   modport master (
      output scan_clk,
      output scan_data,
      output scan_select,
      output scan_latch_enable
   );

   modport slave (
      input scan_clk,
      input scan_data,
      input scan_select,
      input scan_latch_enable
   );

endinterface : scan_design_cell_if

// File: rtl/scan_design_cell.sv
// One link of the scan chain. Shifts serial data on scan_clk rising edges
// (detected in the clk domain), captures the user design outputs, and
// latches the shifted word onto the user design inputs.
module scan_design_cell
   import scan_design_cell_pkg::*;
#(
   parameter int NUM_IOS = NUM_IOS_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   scan_design_cell_if.slave        chain_in,
   scan_design_cell_if.master       chain_out,
   output logic [NUM_IOS-1:0]       design_inputs,
   input  logic [NUM_IOS-1:0]       design_outputs,
   output logic                     inputs_valid,
   output logic [SHIFT_COUNT_W-1:0] shift_count
);

   logic                     scan_clk_prev_q, scan_clk_prev_d;
   logic [NUM_IOS-1:0]       shift_reg_q,     shift_reg_d;
   logic [NUM_IOS-1:0]       design_inputs_q, design_inputs_d;
   logic                     inputs_valid_q,  inputs_valid_d;
   logic [SHIFT_COUNT_W-1:0] shift_count_q,   shift_count_d;

   logic       rise;
   logic       shift_en;
   logic       capture_en;
   logic       latch_en;
   scan_mode_e mode;

   // Control signals are passed straight through so every link sees the same scan_clk phase.
   assign chain_out.scan_clk          = chain_in.scan_clk;
   assign chain_out.scan_select       = chain_in.scan_select;
   assign chain_out.scan_latch_enable = chain_in.scan_latch_enable;
   assign chain_out.scan_data         = shift_reg_q[NUM_IOS-1];

   assign mode       = scan_mode_e'(chain_in.scan_select);
   assign rise       = chain_in.scan_clk & ~scan_clk_prev_q;
   assign latch_en   = chain_in.scan_latch_enable;
   assign shift_en   = rise && (mode == SCAN_SHIFT);
   assign capture_en = (mode == SCAN_CAPTURE) && !latch_en;

   // Next-state logic for edge detect, shift/capture, latch and shift counter.
   always_comb begin
      // NOTE: every _d starts from its hold value so no path leaves it unassigned (no latch).
      scan_clk_prev_d = chain_in.scan_clk;
      shift_reg_d     = shift_reg_q;
      design_inputs_d = design_inputs_q;
      inputs_valid_d  = inputs_valid_q;
      shift_count_d   = shift_count_q;

      if (shift_en) begin
         shift_reg_d   = {shift_reg_q[NUM_IOS-2:0], chain_in.scan_data};
         shift_count_d = sat_inc(shift_count_q);
      end else if (capture_en) begin
         shift_reg_d = design_outputs;
      end

      // Latch takes the pre-shift word and overrides the counter update.
      if (latch_en) begin
         design_inputs_d = shift_reg_q;
         inputs_valid_d  = 1'b1;
         shift_count_d   = '0;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: the data registers are reset too, so a partially shifted word never survives a reset.
      if (reset) begin
         scan_clk_prev_q <= 1'b0;
         shift_reg_q     <= '0;
         design_inputs_q <= '0;
         inputs_valid_q  <= 1'b0;
         shift_count_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
         scan_clk_prev_q <= scan_clk_prev_d;
         shift_reg_q     <= shift_reg_d;
         design_inputs_q <= design_inputs_d;
         inputs_valid_q  <= inputs_valid_d;
         shift_count_q   <= shift_count_d;
      end
   end

   assign design_inputs = design_inputs_q;
   assign inputs_valid  = inputs_valid_q;
   assign shift_count   = shift_count_q;

endmodule : scan_design_cell

// File: tb/tb_scan_design_cell.sv
// Directed self-checking bench for scan_design_cell.
module tb_scan_design_cell;
   import scan_design_cell_pkg::*;

   localparam int N = 8;

   logic         clk;
   logic         reset;
   logic [N-1:0] design_inputs;
   logic [N-1:0] design_outputs;
   logic         inputs_valid;
   logic [7:0]   shift_count;

   int tests_run;
   int tests_failed;

   scan_design_cell_if up_if ();
   scan_design_cell_if dn_if ();

   scan_design_cell #(.NUM_IOS(N)) dut (
      .clk            (clk),
      .reset          (reset),
      .chain_in       (up_if.slave),
      .chain_out      (dn_if.master),
      .design_inputs  (design_inputs),
      .design_outputs (design_outputs),
      .inputs_valid   (inputs_valid),
      .shift_count    (shift_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clk edge; outputs are observed 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One scan_clk period: rise for one cycle, then low for one cycle.
   task automatic shift_bit(input logic b);
      up_if.scan_data = b;
      up_if.scan_clk  = 1'b1;
      step();
      up_if.scan_clk  = 1'b0;
      step();
   endtask

   task automatic shift_word(input logic [N-1:0] w);
      for (int i = N - 1; i >= 0; i--) begin
         shift_bit(w[i]);
      end
   endtask

   task automatic pulse_latch();
      up_if.scan_latch_enable = 1'b1;
      step();
      up_if.scan_latch_enable = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      step();
      step();
      tests_run++;
      if (design_inputs !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_design_inputs: got %h want %h", design_inputs, 8'h00);
      end
      tests_run++;
      if (dn_if.scan_data !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_scan_data_out: got %b want %b", dn_if.scan_data, 1'b0);
      end
      tests_run++;
      if (inputs_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_inputs_valid: got %b want %b", inputs_valid, 1'b0);
      end
      tests_run++;
      if (shift_count !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_shift_count: got %0d want %0d", shift_count, 0);
      end
   endtask

   task automatic test_passthrough();
      logic [2:0] pats [4];
      pats[0] = 3'b101;
      pats[1] = 3'b010;
      pats[2] = 3'b111;
      pats[3] = 3'b000;
      // Held in reset so the pattern cannot disturb cell state.
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         up_if.scan_clk          = pats[i][2];
         up_if.scan_select       = pats[i][1];
         up_if.scan_latch_enable = pats[i][0];
         #1;
         tests_run++;
         if ({dn_if.scan_clk, dn_if.scan_select, dn_if.scan_latch_enable} !== pats[i]) begin
            tests_failed++;
            $display("FAIL passthrough_%0d: got %b want %b", i,
                     {dn_if.scan_clk, dn_if.scan_select, dn_if.scan_latch_enable}, pats[i]);
         end
      end
      up_if.scan_clk          = 1'b0;
      up_if.scan_select       = SCAN_SHIFT;
      up_if.scan_latch_enable = 1'b0;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_shift_latch();
      shift_word(8'hA5);
      tests_run++;
      if (shift_count !== 8'd8) begin
         tests_failed++;
         $display("FAIL shift8_count: got %0d want %0d", shift_count, 8);
      end
      tests_run++;
      if (design_inputs !== 8'h00) begin
         tests_failed++;
         $display("FAIL shift_no_disturb: got %h want %h", design_inputs, 8'h00);
      end
      pulse_latch();
      tests_run++;
      if (design_inputs !== 8'hA5) begin
         tests_failed++;
         $display("FAIL latch_a5: got %h want %h", design_inputs, 8'hA5);
      end
      tests_run++;
      if (inputs_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL latch_valid: got %b want %b", inputs_valid, 1'b1);
      end
      tests_run++;
      if (shift_count !== 8'd0) begin
         tests_failed++;
         $display("FAIL latch_count_clear: got %0d want %0d", shift_count, 0);
      end
      step();
   endtask

   task automatic test_capture();
      logic [7:0] exp_seq;
      logic [7:0] got_seq;
      exp_seq        = 8'b0011_1100;
      got_seq        = '0;
      design_outputs = 8'h3C;
      up_if.scan_select = SCAN_CAPTURE;
      step();
      up_if.scan_select = SCAN_SHIFT;
      design_outputs    = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         // Pre-shift serial output, as seen by the next link at the rise.
         got_seq[i] = dn_if.scan_data;
         shift_bit(1'b0);
      end
      tests_run++;
      if (got_seq !== exp_seq) begin
         tests_failed++;
         $display("FAIL capture_readout: got %b want %b", got_seq, exp_seq);
      end
      tests_run++;
      if (design_inputs !== 8'hA5) begin
         tests_failed++;
         $display("FAIL capture_design_inputs_hold: got %h want %h", design_inputs, 8'hA5);
      end
   endtask

   task automatic test_held_clk();
      pulse_latch();
      step();
      up_if.scan_data = 1'b1;
      up_if.scan_clk  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
      end
      tests_run++;
      if (shift_count !== 8'd1) begin
         tests_failed++;
         $display("FAIL held_clk_count: got %0d want %0d", shift_count, 1);
      end
      up_if.scan_clk = 1'b0;
      step();
      step();
      tests_run++;
      if (shift_count !== 8'd1) begin
         tests_failed++;
         $display("FAIL falling_edge_ignored: got %0d want %0d", shift_count, 1);
      end
   endtask

   task automatic test_latch_with_shift();
      shift_word(8'hFF);
      up_if.scan_data         = 1'b0;
      up_if.scan_clk          = 1'b1;
      up_if.scan_latch_enable = 1'b1;
      step();
      up_if.scan_clk          = 1'b0;
      up_if.scan_latch_enable = 1'b0;
      tests_run++;
      if (design_inputs !== 8'hFF) begin
         tests_failed++;
         $display("FAIL latch_shift_old_word: got %h want %h", design_inputs, 8'hFF);
      end
      tests_run++;
      if (shift_count !== 8'd0) begin
         tests_failed++;
         $display("FAIL latch_shift_count: got %0d want %0d", shift_count, 0);
      end
      step();
      pulse_latch();
      tests_run++;
      if (design_inputs !== 8'hFE) begin
         tests_failed++;
         $display("FAIL latch_shift_new_reg: got %h want %h", design_inputs, 8'hFE);
      end
      step();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 255; i++) begin
         shift_bit(1'b0);
      end
      tests_run++;
      if (shift_count !== 8'd255) begin
         tests_failed++;
         $display("FAIL count_255: got %0d want %0d", shift_count, 255);
      end
      for (int i = 0; i < 5; i++) begin
         shift_bit(1'b1);
      end
      tests_run++;
      if (shift_count !== 8'd255) begin
         tests_failed++;
         $display("FAIL count_saturate: got %0d want %0d", shift_count, 255);
      end
   endtask

   task automatic test_reset_mid_shift();
      shift_bit(1'b1);
      shift_bit(1'b1);
      shift_bit(1'b0);
      shift_bit(1'b1);
      do_reset();
      tests_run++;
      if ({design_inputs, inputs_valid, shift_count, dn_if.scan_data} !== 18'd0) begin
         tests_failed++;
         $display("FAIL mid_reset_clear: got di=%h v=%b cnt=%0d so=%b want all 0",
                  design_inputs, inputs_valid, shift_count, dn_if.scan_data);
      end
      shift_word(8'h5A);
      pulse_latch();
      tests_run++;
      if (design_inputs !== 8'h5A || inputs_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_reset_reload: got %h/%b want %h/%b",
                  design_inputs, inputs_valid, 8'h5A, 1'b1);
      end
      step();
   endtask

   task automatic test_latch_no_capture();
      design_outputs          = 8'h99;
      up_if.scan_select       = SCAN_CAPTURE;
      up_if.scan_latch_enable = 1'b1;
      step();
      up_if.scan_select       = SCAN_SHIFT;
      up_if.scan_latch_enable = 1'b0;
      step();
      pulse_latch();
      tests_run++;
      if (design_inputs !== 8'h5A) begin
         tests_failed++;
         $display("FAIL latch_blocks_capture: got %h want %h", design_inputs, 8'h5A);
      end
      step();
   endtask

   initial begin
      tests_run               = 0;
      tests_failed            = 0;
      reset                   = 1'b1;
      design_outputs          = '0;
      up_if.scan_clk          = 1'b0;
      up_if.scan_data         = 1'b0;
      up_if.scan_select       = SCAN_SHIFT;
      up_if.scan_latch_enable = 1'b0;

      test_reset();
      test_passthrough();
      test_shift_latch();
      test_capture();
      test_held_clk();
      test_latch_with_shift();
      test_saturation();
      test_reset_mid_shift();
      test_latch_no_capture();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_scan_design_cell
